// File: rtl/ixc_assign_pipe.sv
// Registered, elastic replacement for a plain L <- R bit assign: DEPTH valid/ready
// stages with flush, occupancy count and an optional per-bit hold mask.
module ixc_assign_pipe #(
  parameter int WIDTH   = 22,
  parameter int DEPTH   = 2,
  parameter bit MASK_EN = 1'b0,
  localparam int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  // S0 is the input side, S[DEPTH-1] drives the outputs.
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] unload;
  logic [WIDTH-1:0] d [DEPTH];
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] mask_eff;
  logic [WIDTH-1:0] in_word;
  logic             accept;
  logic             can_take;

  // Ready chain walks from the output back to S0 so a full pipe still streams.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    load     = '0;
    unload   = '0;
    can_take = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      unload[i] = v[i] & can_take;
      load[i]   = ~v[i] | unload[i];
      can_take  = load[i];
    end
  end

  assign mask_eff  = MASK_EN ? in_mask : {WIDTH{1'b1}};
  assign in_word   = (in_data & mask_eff) | (shadow & ~mask_eff);
  assign in_ready  = ~rst & ~flush & load[0];
  assign accept    = in_valid & in_ready;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the pre-edge value of its neighbour.
  always_ff @(posedge clk) begin
    if (rst) begin
      v         <= '0;
      shadow    <= '0;
      occupancy <= '0;
      // NOTE: the data stages are reset too, so out_data reads zero after reset.
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else begin
      if (accept) begin
        shadow <= in_word;
        d[0]   <= in_word;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (load[i] && v[i-1]) d[i] <= d[i-1];
      end
      // Flush drops valid bits only; a handshaking output word is still consumed.
      if (flush) begin
        v         <= '0;
        occupancy <= '0;
      end else begin
        if (load[0]) v[0] <= accept;
        for (int i = 1; i < DEPTH; i++) begin
          if (load[i]) v[i] <= v[i-1];
        end
        occupancy <= occupancy + OCC_W'(accept) - OCC_W'(unload[DEPTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_ixc_assign_pipe.sv
// Bench for ixc_assign_pipe: two instances (DEPTH=2 unmasked, DEPTH=3 masked)
// checked every cycle against a queue-of-words position model plus scenario checks.
module tb_ixc_assign_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        flush     [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [21:0] in_data   [2];
  logic [21:0] in_mask   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [21:0] out_data  [2];
  logic [1:0]  occ       [2];

  ixc_assign_pipe #(.WIDTH(22), .DEPTH(2), .MASK_EN(1'b0)) u_a (
    .clk(clk), .rst(rst[0]), .flush(flush[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .in_data(in_data[0]), .in_mask(in_mask[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .occupancy(occ[0])
  );

  ixc_assign_pipe #(.WIDTH(22), .DEPTH(3), .MASK_EN(1'b1)) u_b (
    .clk(clk), .rst(rst[1]), .flush(flush[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .in_data(in_data[1]), .in_mask(in_mask[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .occupancy(occ[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: ordered list of words, each with its position (0 = input side).
  int          dep [2] = '{2, 3};
  logic [21:0] md  [2][4];
  int          mp  [2][4];
  int          mn  [2] = '{0, 0};
  logic [21:0] sh  [2] = '{22'h0, 22'h0};

  // Log of words observed leaving each instance.
  logic [21:0] dlv  [2][256];
  int          dcyc [2][256];
  int          dn   [2] = '{0, 0};
  int          cyc = 0;

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0; flush[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b1;
      in_data[k] = '0; in_mask[k] = '1;
    end
  endtask

  task automatic clear_log();
    dn[0] = 0;
    dn[1] = 0;
  endtask

  // Compare every output against the model, then step model and clock one edge.
  task automatic advance();
    #3;
    for (int k = 0; k < 2; k++) begin
      logic        exp_vld, exp_rdy, hs;
      logic [21:0] m, word;
      int          prev, n;
      int          np [4];
      exp_vld = (mn[k] > 0) && (mp[k][0] == dep[k] - 1);
      hs      = exp_vld && out_ready[k];
      prev    = dep[k];
      for (int j = 0; j < mn[k]; j++) begin
        if (j == 0 && hs) prev = dep[k];
        else begin
          np[j] = (mp[k][j] + 1 < prev - 1) ? mp[k][j] + 1 : prev - 1;
          prev  = np[j];
        end
      end
      exp_rdy = !rst[k] && !flush[k] && (prev >= 1);

      n_checks++;
      if (in_ready[k] !== exp_rdy) begin
        n_errors++;
        $display("FAIL model_in_ready inst%0d cyc%0d: got %b want %b", k, cyc, in_ready[k], exp_rdy);
      end
      n_checks++;
      if (out_valid[k] !== exp_vld) begin
        n_errors++;
        $display("FAIL model_out_valid inst%0d cyc%0d: got %b want %b", k, cyc, out_valid[k], exp_vld);
      end
      n_checks++;
      if (occ[k] !== 2'(mn[k])) begin
        n_errors++;
        $display("FAIL model_occupancy inst%0d cyc%0d: got %0d want %0d", k, cyc, occ[k], mn[k]);
      end
      if (exp_vld) begin
        n_checks++;
        if (out_data[k] !== md[k][0]) begin
          n_errors++;
          $display("FAIL model_out_data inst%0d cyc%0d: got %h want %h", k, cyc, out_data[k], md[k][0]);
        end
      end

      if (out_valid[k] === 1'b1 && out_ready[k] && dn[k] < 256) begin
        dlv[k][dn[k]]  = out_data[k];
        dcyc[k][dn[k]] = cyc;
        dn[k]++;
      end

      if (rst[k]) begin
        mn[k] = 0;
        sh[k] = '0;
      end else if (flush[k]) begin
        mn[k] = 0;
      end else begin
        n = 0;
        for (int j = 0; j < mn[k]; j++) begin
          if (!(j == 0 && hs)) begin
            md[k][n] = md[k][j];
            mp[k][n] = np[j];
            n++;
          end
        end
        if (in_valid[k] && exp_rdy) begin
          m        = (k == 1) ? in_mask[k] : 22'h3FFFFF;
          word     = (in_data[k] & m) | (sh[k] & ~m);
          md[k][n] = word;
          mp[k][n] = 0;
          n++;
          sh[k] = word;
        end
        mn[k] = n;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; flush[k] = 1'b1; in_valid[k] = 1'b1; out_ready[k] = 1'b1;
      in_data[k] = 22'h155555;
    end
    repeat (2) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (in_ready[k] !== 1'b0) begin
          n_errors++;
          $display("FAIL reset_in_ready inst%0d: got %b want 0", k, in_ready[k]);
        end
      end
      advance();
    end
    idle();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (out_valid[k] !== 1'b0 || out_data[k] !== 22'h0 || occ[k] !== 2'd0 || in_ready[k] !== 1'b1) begin
        n_errors++;
        $display("FAIL reset_state inst%0d: got v=%b d=%h occ=%0d rdy=%b want v=0 d=0 occ=0 rdy=1",
                 k, out_valid[k], out_data[k], occ[k], in_ready[k]);
      end
    end
    advance();
  endtask

  task automatic test_latency();
    idle(); clear_log();
    in_data[0] = 22'h3A5C1F; in_valid[0] = 1'b1;
    #1;
    n_checks++;
    if (in_ready[0] !== 1'b1 || occ[0] !== 2'd0) begin
      n_errors++;
      $display("FAIL lat_start: got rdy=%b occ=%0d want rdy=1 occ=0", in_ready[0], occ[0]);
    end
    advance();
    in_valid[0] = 1'b0;
    #1;
    n_checks++;
    if (out_valid[0] !== 1'b0 || occ[0] !== 2'd1) begin
      n_errors++;
      $display("FAIL lat_edge1: got v=%b occ=%0d want v=0 occ=1", out_valid[0], occ[0]);
    end
    advance();
    #1;
    n_checks++;
    if (out_valid[0] !== 1'b1 || out_data[0] !== 22'h3A5C1F || occ[0] !== 2'd1) begin
      n_errors++;
      $display("FAIL lat_edge2: got v=%b d=%h occ=%0d want v=1 d=3a5c1f occ=1", out_valid[0], out_data[0], occ[0]);
    end
    advance();
    #1;
    n_checks++;
    if (out_valid[0] !== 1'b0 || occ[0] !== 2'd0) begin
      n_errors++;
      $display("FAIL lat_edge3: got v=%b occ=%0d want v=0 occ=0", out_valid[0], occ[0]);
    end
    advance();
    n_checks++;
    if (dn[0] !== 1) begin
      n_errors++;
      $display("FAIL lat_count: got %0d want 1", dn[0]);
    end
  endtask

  task automatic test_streaming();
    int bad_rdy = 0;
    int bad_occ = 0;
    int bad_dat = 0;
    idle(); clear_log();
    for (int i = 0; i < 100; i++) begin
      in_data[0] = 22'(i); in_valid[0] = 1'b1;
      #1;
      if (in_ready[0] !== 1'b1) bad_rdy++;
      if (i >= 2 && occ[0] !== 2'd2) bad_occ++;
      advance();
    end
    in_valid[0] = 1'b0;
    repeat (3) advance();
    n_checks++;
    if (bad_rdy != 0 || bad_occ != 0) begin
      n_errors++;
      $display("FAIL stream_steady: got %0d ready drops, %0d occupancy errors want 0 and 0", bad_rdy, bad_occ);
    end
    n_checks++;
    if (dn[0] !== 100) begin
      n_errors++;
      $display("FAIL stream_count: got %0d want 100", dn[0]);
    end else begin
      for (int i = 0; i < 100; i++) if (dlv[0][i] !== 22'(i)) bad_dat++;
      n_checks++;
      if (bad_dat != 0 || dcyc[0][99] - dcyc[0][0] != 99) begin
        n_errors++;
        $display("FAIL stream_order: got %0d wrong words, span %0d want 0 wrong, span 99",
                 bad_dat, dcyc[0][99] - dcyc[0][0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [21:0] w [5];
    int sent = 0;
    int guard = 0;
    idle(); clear_log();
    out_ready[1] = 1'b0;
    for (int i = 0; i < 5; i++) w[i] = 22'($urandom);
    for (int c = 0; c < 5; c++) begin
      in_data[1] = w[sent]; in_valid[1] = 1'b1;
      #1;
      n_checks++;
      if (in_ready[1] !== (c < 3)) begin
        n_errors++;
        $display("FAIL bp_fill_ready c%0d: got %b want %b", c, in_ready[1], (c < 3));
      end
      if (c >= 3) begin
        n_checks++;
        if (out_valid[1] !== 1'b1 || out_data[1] !== w[0]) begin
          n_errors++;
          $display("FAIL bp_hold c%0d: got v=%b d=%h want v=1 d=%h", c, out_valid[1], out_data[1], w[0]);
        end
      end
      if (in_ready[1] === 1'b1) sent++;
      advance();
    end
    n_checks++;
    if (occ[1] !== 2'd3) begin
      n_errors++;
      $display("FAIL bp_full_occ: got %0d want 3", occ[1]);
    end
    out_ready[1] = 1'b1;
    while (dn[1] < 5 && guard < 20) begin
      in_valid[1] = (sent < 5);
      in_data[1]  = (sent < 5) ? w[sent] : 22'h0;
      #1;
      if (guard == 0) begin
        n_checks++;
        if (in_ready[1] !== 1'b1) begin
          n_errors++;
          $display("FAIL bp_ready_return: got %b want 1", in_ready[1]);
        end
      end
      if (in_valid[1] && in_ready[1] === 1'b1) sent++;
      advance();
      guard++;
    end
    in_valid[1] = 1'b0;
    n_checks++;
    if (dn[1] !== 5) begin
      n_errors++;
      $display("FAIL bp_drain_count: got %0d want 5", dn[1]);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (dlv[1][i] !== w[i]) begin
          n_errors++;
          $display("FAIL bp_order word%0d: got %h want %h", i, dlv[1][i], w[i]);
        end
      end
    end
  endtask

  task automatic test_flush();
    logic [21:0] y;
    idle(); clear_log();
    out_ready[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_data[1] = 22'($urandom); in_valid[1] = 1'b1;
      advance();
    end
    flush[1] = 1'b1; in_valid[1] = 1'b1; in_data[1] = 22'h2BAD11;
    #1;
    n_checks++;
    if (in_ready[1] !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_no_accept: got %b want 0", in_ready[1]);
    end
    advance();
    flush[1] = 1'b0; in_valid[1] = 1'b0;
    #1;
    n_checks++;
    if (out_valid[1] !== 1'b0 || occ[1] !== 2'd0) begin
      n_errors++;
      $display("FAIL flush_empty: got v=%b occ=%0d want v=0 occ=0", out_valid[1], occ[1]);
    end
    y = 22'($urandom);
    in_data[1] = y; in_valid[1] = 1'b1; out_ready[1] = 1'b1;
    advance();
    in_valid[1] = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      #1;
      n_checks++;
      if (out_valid[1] !== (e == 3) || (e == 3 && out_data[1] !== y)) begin
        n_errors++;
        $display("FAIL flush_relatency e%0d: got v=%b d=%h want v=%b d=%h", e, out_valid[1], out_data[1], (e == 3), y);
      end
      advance();
    end
    n_checks++;
    if (dn[1] !== 1 || dlv[1][0] !== y) begin
      n_errors++;
      $display("FAIL flush_delivered: got n=%0d d=%h want n=1 d=%h", dn[1], dlv[1][0], y);
    end
  endtask

  task automatic test_mask();
    idle(); clear_log();
    in_data[1] = 22'h3FFFFF; in_mask[1] = 22'h3FFFFF; in_valid[1] = 1'b1;
    in_data[0] = 22'h012345; in_mask[0] = 22'h000000; in_valid[0] = 1'b1;
    advance();
    in_data[1] = 22'h000000; in_mask[1] = 22'h00000F;
    in_valid[0] = 1'b0; in_mask[0] = '1;
    advance();
    in_valid[1] = 1'b0; in_mask[1] = '1;
    repeat (4) advance();
    n_checks++;
    if (dn[1] !== 2 || dlv[1][0] !== 22'h3FFFFF || dlv[1][1] !== 22'h3FFFF0) begin
      n_errors++;
      $display("FAIL mask_hold: got n=%0d %h %h want n=2 3fffff 3ffff0", dn[1], dlv[1][0], dlv[1][1]);
    end
    n_checks++;
    if (dn[0] !== 1 || dlv[0][0] !== 22'h012345) begin
      n_errors++;
      $display("FAIL mask_ignored: got n=%0d %h want n=1 012345", dn[0], dlv[0][0]);
    end
  endtask

  task automatic test_reset_mid();
    idle(); clear_log();
    out_ready[1] = 1'b0;
    in_data[1] = 22'($urandom) | 22'h1; in_valid[1] = 1'b1;
    advance();
    in_valid[1] = 1'b0;
    advance();
    in_data[1] = 22'($urandom) | 22'h1; in_valid[1] = 1'b1;
    advance();
    in_valid[1] = 1'b0;
    #1;
    n_checks++;
    if (occ[1] !== 2'd2 || out_valid[1] !== 1'b1) begin
      n_errors++;
      $display("FAIL rmid_before: got occ=%0d v=%b want occ=2 v=1", occ[1], out_valid[1]);
    end
    rst[1] = 1'b1;
    advance();
    rst[1] = 1'b0;
    #1;
    n_checks++;
    if (out_valid[1] !== 1'b0 || out_data[1] !== 22'h0 || occ[1] !== 2'd0 || in_ready[1] !== 1'b1) begin
      n_errors++;
      $display("FAIL rmid_after: got v=%b d=%h occ=%0d rdy=%b want v=0 d=0 occ=0 rdy=1",
               out_valid[1], out_data[1], occ[1], in_ready[1]);
    end
    in_data[1] = 22'h2A5A5A; in_mask[1] = 22'h0; in_valid[1] = 1'b1; out_ready[1] = 1'b1;
    advance();
    in_valid[1] = 1'b0; in_mask[1] = '1;
    repeat (3) advance();
    n_checks++;
    if (dn[1] !== 1 || dlv[1][0] !== 22'h0) begin
      n_errors++;
      $display("FAIL rmid_shadow: got n=%0d d=%h want n=1 d=000000", dn[1], dlv[1][0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 2; k++) begin
        rst[k]       = ($urandom_range(0, 199) == 0);
        flush[k]     = ($urandom_range(0, 39) == 0);
        in_valid[k]  = ($urandom_range(0, 9) < 7);
        out_ready[k] = ((c / 100) % 2 == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
        in_data[k]   = 22'($urandom);
        in_mask[k]   = 22'($urandom);
      end
      advance();
    end
    idle();
    repeat (4) advance();
  endtask

  initial begin
    idle();
    rst[0] = 1'b1; rst[1] = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    test_reset();
    test_latency();
    test_streaming();
    test_backpressure();
    test_flush();
    test_mask();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
